// File: rtl/register_bank_mp_if.sv
// Bus bundle for register_bank_mp: multi-port read, one write port, scoreboard set.
interface register_bank_mp_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned NREAD  = 2
);
   logic [NREAD*ADDR_W-1:0] rd_addr;
   logic [NREAD*DATA_W-1:0] rd_data;
   logic [NREAD-1:0]        rd_busy;
   logic                    wr_en;
   logic [ADDR_W-1:0]       wr_addr;
   logic [DATA_W-1:0]       wr_data;
   logic                    busy_set;
   logic [ADDR_W-1:0]       busy_addr;
   logic                    any_busy;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, busy_set, busy_addr,
      input  rd_data, rd_busy, any_busy
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, busy_set, busy_addr,
      output rd_data, rd_busy, any_busy
   );
endinterface

// File: rtl/register_bank_mp.sv
// Multi-read-port register bank with per-register pending scoreboard; r0 hardwired to zero.
// Define REGISTER_BANK_MP_BYPASS_EN to forward same-cycle write data/pending state to reads.
module register_bank_mp #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned NREAD  = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   register_bank_mp_if.slave  bus
);
   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
   logic [DEPTH-1:0]             pend_q, pend_d;
   logic [NREAD*DATA_W-1:0]      rd_data_c;
   logic [NREAD-1:0]             rd_busy_c;
   logic [ADDR_W-1:0]            ra;

   // Write clears pending, busy_set applied last so a new producer wins on collision.
   always_comb begin
      regs_d = regs_q;
      pend_d = pend_q;
      if (bus.wr_en && (bus.wr_addr != '0)) begin
         regs_d[bus.wr_addr] = bus.wr_data;
         pend_d[bus.wr_addr] = 1'b0;
      end
      if (bus.busy_set && (bus.busy_addr != '0)) begin
         pend_d[bus.busy_addr] = 1'b1;
      end
      regs_d[0] = '0;
      pend_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_q <= '0;
         pend_q <= '0;
      end else begin
         regs_q <= regs_d;
         pend_q <= pend_d;
      end
   end

   // Combinational read ports; forwarding is gated by rst_n so reads stay zero in reset.
   always_comb begin
      rd_data_c = '0;
      rd_busy_c = '0;
      ra        = '0;
      for (int k = 0; k < int'(NREAD); k++) begin
         ra = bus.rd_addr[k*ADDR_W +: ADDR_W];
         rd_data_c[k*DATA_W +: DATA_W] = regs_q[ra];
         rd_busy_c[k]                  = pend_q[ra];
`ifdef REGISTER_BANK_MP_BYPASS_EN
         if (rst_n && bus.wr_en && (bus.wr_addr != '0) && (bus.wr_addr == ra)) begin
            rd_data_c[k*DATA_W +: DATA_W] = bus.wr_data;
            rd_busy_c[k]                  = bus.busy_set && (bus.busy_addr == ra);
         end
`endif
      end
   end

   assign bus.rd_data  = rd_data_c;
   assign bus.rd_busy  = rd_busy_c;
   assign bus.any_busy = |pend_q;
endmodule

// File: doc/register_bank_mp.md
REGISTER_BANK_MP -- requirements
Module: register_bank_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; depth = 2**ADDR_W registers.
REQ-003 SHALL have parameter NREAD, default 2, number of read ports (1..4).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rd_addr  input  NREAD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W].
REQ-007 SHALL have port rd_data  output  NREAD*DATA_W  packed read data; port k at bits [k*DATA_W +: DATA_W].
REQ-008 SHALL have port rd_busy  output  NREAD  per-port pending flag of the addressed register.
REQ-009 SHALL have port wr_en  input  1  write request.
REQ-010 SHALL have port wr_addr  input  ADDR_W  write address.
REQ-011 SHALL have port wr_data  input  DATA_W  write data.
REQ-012 SHALL have port busy_set  input  1  mark busy_addr as pending (producer issued).
REQ-013 SHALL have port busy_addr  input  ADDR_W  register to mark pending.
REQ-014 SHALL have port any_busy  output  1  high when any pending bit is set.

Function
REQ-015 Reads SHALL be combinational, zero latency: rd_data[k] = reg[rd_addr[k]], independent per port.
REQ-016 Register 0 SHALL always read 0; writes to address 0 SHALL be ignored.
REQ-017 When wr_en=1 and wr_addr!=0, reg[wr_addr] SHALL take wr_data on the next rising clk edge.
REQ-018 Scoreboard: one pending bit per register; busy_set=1 and busy_addr!=0 SHALL set bit busy_addr at the next edge.
REQ-019 wr_en=1 and wr_addr!=0 SHALL clear pending bit wr_addr at the next edge.
REQ-020 Same address, busy_set and wr_en in the same cycle: data SHALL be written and the pending bit SHALL end set (new producer wins).
REQ-021 Different addresses, busy_set and wr_en in the same cycle: both actions SHALL take effect.
REQ-022 Pending bit 0 SHALL be constant 0; rd_busy[k] SHALL be 0 whenever rd_addr[k]=0.
REQ-023 rd_busy[k] SHALL equal pending[rd_addr[k]] (combinational); any_busy SHALL be the OR of all pending bits.
REQ-024 Multiple read ports addressing the same register SHALL all return identical data and busy values.

Reset
REQ-025 rst_n=0 SHALL immediately, without clk, clear all registers to 0 and all pending bits to 0.
REQ-026 While rst_n=0: rd_data SHALL read 0 for all ports, rd_busy=0, any_busy=0; writes and busy_set SHALL be ignored.
REQ-027 Reset asserted mid-operation SHALL discard any write or busy_set in that cycle; the first update SHALL occur on the first rising edge after rst_n returns high.

Configuration
REQ-028 Macro REGISTER_BANK_MP_BYPASS_EN SHALL select write-to-read forwarding.
REQ-029 With REGISTER_BANK_MP_BYPASS_EN defined: wr_en=1, wr_addr!=0, rd_addr[k]=wr_addr SHALL give rd_data[k]=wr_data and rd_busy[k]=0 in the same cycle, unless busy_set targets the same address, in which case rd_busy[k]=1.
REQ-030 Without the macro: reads SHALL return the stored (pre-write) value and the stored pending bit until the clock edge.

Verification
REQ-031 Reset: drive rst_n=0 after writing 0xDEADBEEF to r5 -> rd_data for r5 = 0 and any_busy=0 immediately, before any clk edge.
REQ-032 r0 protection: write 0x12345678 to r0, busy_set r0 -> all ports read r0 = 0, rd_busy=0, any_busy=0.
REQ-033 Multi-port: write r3=0xA5A5A5A5, r7=0x0000FFFF; read ports 0/1 = r3/r7, then both = r7 -> 0xA5A5A5A5/0x0000FFFF, then 0x0000FFFF on both.
REQ-034 Scoreboard: busy_set r9 -> rd_busy=1, any_busy=1 next cycle; write r9=0x55 -> rd_busy=0, any_busy=0 after the edge, data 0x55.
REQ-035 Collision: same cycle busy_set r4 and write r4=0x77 -> after the edge r4 = 0x77 and rd_busy=1.
REQ-036 Bypass: write r6=0x11 then in one cycle write r6=0x22 while reading r6 -> 0x22 with macro defined, 0x11 without; 0x22 after the edge in both builds.
